// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    HUNT0   = 3'd0,
    HUNT1   = 3'd1,
    LEN     = 3'd2,
    PAYLOAD = 3'd3,
    CSUM    = 3'd4,
    DRAIN   = 3'd5
  } state_t;

  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] DEF_HDR0 = 8'h55;
  localparam logic [7:0] DEF_HDR1 = 8'hAA;

  // Index width for a buffer of the given depth; a depth of 1 still needs one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 register file, one synchronous write port,
// one asynchronous read port.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          i_clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Store one payload byte per write strobe.
  always_ff @(posedge i_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_parser.sv
// Frame hunter for the UART byte stream: finds {HDR0, HDR1, LEN, PAYLOAD, CSUM},
// buffers and checks the payload, then replays good frames on valid/ready.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  HUNT0   | idle, waiting for HDR0
//  HUNT1   | HDR0 seen, waiting for HDR1 (HDR0 again keeps us here)
//  LEN     | header complete, next byte is the payload length
//  PAYLOAD | storing payload bytes and accumulating the checksum
//  CSUM    | next byte is compared against the running sum
//  DRAIN   | good frame replayed downstream; new bytes are discarded
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] HDR0           = DEF_HDR0,
  parameter logic [7:0] HDR1           = DEF_HDR1,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 27_000,
  parameter int         CNT_W          = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_last,
  output logic [7:0] o_len,
  output logic       o_err,
  output logic [1:0] o_err_code,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int IDX_W = idx_width(MAX_LEN);

  state_t             state, state_nxt;
  logic               rx_prev;
  logic               strobe;
  logic [7:0]         len_r;
  logic [7:0]         len_m1;
  logic [7:0]         sum;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   rd;
  logic               idx_last;
  logic               rd_last;
  logic [CNT_W-1:0]   tmo_cnt;
  logic               counting;
  logic               tmo_hit;
  logic               err_ev;
  logic [1:0]         err_code_nxt;
  logic               handshake;
  logic               buf_we;
  logic [7:0]         rdata;

  assign strobe    = i_rx_valid && !rx_prev;
  assign len_m1    = len_r - 8'd1;
  assign idx_last  = (8'(idx) == len_m1);
  assign rd_last   = (8'(rd) == len_m1);
  assign counting  = (state == HUNT1) || (state == LEN) ||
                     (state == PAYLOAD) || (state == CSUM);
  // A strobe landing on the terminal count wins over the timeout.
  assign tmo_hit   = counting && !strobe && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign handshake = (state == DRAIN) && i_ready;
  assign buf_we    = strobe && (state == PAYLOAD);

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (IDX_W)
  ) u_buf (
    .i_clk (i_clk),
    .we    (buf_we),
    .waddr (idx),
    .wdata (i_rx_data),
    .raddr (rd),
    .rdata (rdata)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= HUNT0;
    else       state <= state_nxt;
  end

  // Next-state decode plus the drop event that goes with each bad exit.
  always_comb begin
    state_nxt    = state;
    err_ev       = 1'b0;
    err_code_nxt = ERR_LEN;
    case (state)
      HUNT0: begin
        if (strobe && i_rx_data == HDR0) state_nxt = HUNT1;
      end
      HUNT1: begin
        if (strobe) begin
          if (i_rx_data == HDR1)      state_nxt = LEN;
          else if (i_rx_data != HDR0) state_nxt = HUNT0;
        end
      end
      LEN: begin
        if (strobe) begin
          if (i_rx_data != 8'd0 && i_rx_data <= 8'(MAX_LEN)) begin
            state_nxt = PAYLOAD;
          end else begin
            state_nxt    = HUNT0;
            err_ev       = 1'b1;
            err_code_nxt = ERR_LEN;
          end
        end
      end
      PAYLOAD: begin
        if (strobe && idx_last) state_nxt = CSUM;
      end
      CSUM: begin
        if (strobe) begin
          if (i_rx_data == sum) begin
            state_nxt = DRAIN;
          end else begin
            state_nxt    = HUNT0;
            err_ev       = 1'b1;
            err_code_nxt = ERR_CSUM;
          end
        end
      end
      DRAIN: begin
        if (handshake && rd_last) state_nxt = HUNT0;
      end
      default: state_nxt = HUNT0;
    endcase
    if (tmo_hit) begin
      state_nxt    = HUNT0;
      err_ev       = 1'b1;
      err_code_nxt = ERR_TIMEOUT;
    end
  end

  // Stream outputs follow the state; data is forced to zero outside DRAIN.
  always_comb begin
    o_valid = (state == DRAIN);
    o_last  = o_valid && rd_last;
    o_data  = o_valid ? rdata : 8'h00;
    o_busy  = (state != HUNT0);
  end

  // Edge detect, counters, running sum and registered status outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_prev    <= 1'b0;
      len_r      <= 8'd0;
      sum        <= 8'd0;
      idx        <= '0;
      rd         <= '0;
      tmo_cnt    <= '0;
      o_len      <= 8'd0;
      o_err      <= 1'b0;
      o_err_code <= 2'd0;
      o_overrun  <= 1'b0;
    end else begin
      rx_prev   <= i_rx_valid;
      o_err     <= err_ev;
      o_overrun <= strobe && (state == DRAIN);
      if (err_ev) o_err_code <= err_code_nxt;

      if (strobe || !counting || tmo_hit) tmo_cnt <= '0;
      else                                tmo_cnt <= tmo_cnt + 1'b1;

      if (strobe) begin
        case (state)
          LEN: begin
            if (state_nxt == PAYLOAD) begin
              len_r <= i_rx_data;
              sum   <= i_rx_data;
              idx   <= '0;
            end
          end
          PAYLOAD: begin
            sum <= sum + i_rx_data;
            if (!idx_last) idx <= idx + 1'b1;
          end
          CSUM: begin
            if (state_nxt == DRAIN) begin
              rd    <= '0;
              o_len <= len_r;
            end
          end
          default: ;
        endcase
      end

      if (handshake && !rd_last) rd <= rd + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: frames are built from the protocol
// rules, their expected outcome queued, and a monitor checks the DUT outputs.
module tb_uart_frame_parser;

  localparam int TMO     = 300;
  localparam int MAXL    = 16;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic [7:0] len;
  } exp_t;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_rx_data = 8'h00;
  logic       i_rx_valid = 1'b0;
  logic       i_ready = 1'b1;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_last;
  logic [7:0] o_len;
  logic       o_err;
  logic [1:0] o_err_code;
  logic       o_overrun;
  logic       o_busy;

  exp_t data_q[$];
  int   err_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ovr_exp = 0;
  int   ovr_seen = 0;
  int   ready_mode = 0;

  uart_frame_parser #(
    .MAX_LEN        (MAXL),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (16)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_last     (o_last),
    .o_len      (o_len),
    .o_err      (o_err),
    .o_err_code (o_err_code),
    .o_overrun  (o_overrun),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Downstream ready pattern: 0 always, 1 toggle, 2 random, 3 stalled.
  always @(posedge i_clk) begin
    #1;
    case (ready_mode)
      0:       i_ready = 1'b1;
      1:       i_ready = ~i_ready;
      2:       i_ready = 1'($urandom_range(0, 1));
      default: i_ready = 1'b0;
    endcase
  end

  // Monitor: compares every presented byte against the queue head, pops on
  // handshake, and matches drop pulses against the expected error codes.
  always @(negedge i_clk) begin
    exp_t e;
    if (!i_rst) begin
      if (o_valid) begin
        checks++;
        if (data_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: o_data=%02h with nothing expected", o_data);
        end else begin
          e = data_q[0];
          if (o_data !== e.d || o_last !== e.last || o_len !== e.len) begin
            errors++;
            $display("FAIL stream: got data=%02h last=%0b len=%0d, expected data=%02h last=%0b len=%0d",
                     o_data, o_last, o_len, e.d, e.last, e.len);
          end
          if (i_ready) void'(data_q.pop_front());
        end
      end
      if (o_err) begin
        checks++;
        if (err_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_err: code=%0d with no drop expected", o_err_code);
        end else begin
          if (int'(o_err_code) != err_q[0]) begin
            errors++;
            $display("FAIL err_code: got %0d expected %0d", o_err_code, err_q[0]);
          end
          void'(err_q.pop_front());
        end
      end
      if (o_overrun) ovr_seen++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; valid held for 'hold' edges, then low for 'gap' edges.
  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    repeat (hold) @(posedge i_clk);
    #1;
    i_rx_valid = 1'b0;
    repeat (gap) @(posedge i_clk);
    #1;
  endtask

  function automatic logic [7:0] frame_sum(input bq_t p);
    int s;
    s = p.size();
    foreach (p[i]) s += int'(p[i]);
    return 8'(s % 256);
  endfunction

  // Sends a complete frame; csum_xor != 0 corrupts the checksum.
  task automatic send_frame(input bq_t p, input logic [7:0] csum_xor,
                            input int extra_hdr, input int hold, input int gap);
    logic [7:0] cs;
    exp_t e;
    cs = frame_sum(p) ^ csum_xor;
    if (csum_xor != 8'h00) begin
      err_q.push_back(2);
    end else begin
      foreach (p[i]) begin
        e.d    = p[i];
        e.last = (i == p.size() - 1);
        e.len  = 8'(p.size());
        data_q.push_back(e);
      end
    end
    repeat (extra_hdr) send_byte(8'h55, hold, gap);
    send_byte(8'h55, hold, gap);
    send_byte(8'hAA, hold, gap);
    send_byte(8'(p.size()), hold, gap);
    foreach (p[i]) send_byte(p[i], hold, gap);
    send_byte(cs, hold, gap);
  endtask

  task automatic send_bad_len(input logic [7:0] len, input int hold, input int gap);
    err_q.push_back(1);
    send_byte(8'h55, hold, gap);
    send_byte(8'hAA, hold, gap);
    send_byte(len, hold, gap);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((data_q.size() != 0 || err_q.size() != 0 || o_busy) && n < budget) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL wait_idle: timed out with %0d bytes and %0d drops outstanding, busy=%0b",
               data_q.size(), err_q.size(), o_busy);
      data_q.delete();
      err_q.delete();
    end
  endtask

  function automatic bq_t rand_payload(input int len);
    bq_t p;
    for (int i = 0; i < len; i++) p.push_back(8'($urandom_range(0, 255)));
    return p;
  endfunction

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bq_t p;
    int  n;
    logic [7:0] g;

    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_last", o_last, 0);
    chk("rst_len", o_len, 0);
    chk("rst_err", o_err, 0);
    chk("rst_code", o_err_code, 0);
    chk("rst_ovr", o_overrun, 0);
    chk("rst_busy", o_busy, 0);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    // Good frame; checksum covers LEN: 03+11+22+33 = 69.
    ready_mode = 0;
    p = '{8'h11, 8'h22, 8'h33};
    chk("csum_model", frame_sum(p), 8'h69);
    send_frame(p, 8'h00, 0, 1, 1);
    wait_idle(500);
    chk("len_after_good", o_len, 3);

    // Same frame with a corrupt checksum (67 instead of 69).
    send_frame(p, 8'h69 ^ 8'h67, 0, 1, 1);
    wait_idle(500);
    chk("code_csum", o_err_code, 2);
    chk("len_held", o_len, 3);

    // Zero and over-size lengths, then a good frame.
    send_bad_len(8'h00, 1, 1);
    wait_idle(500);
    send_bad_len(8'h11, 1, 1);
    wait_idle(500);
    chk("code_len", o_err_code, 1);
    send_frame(rand_payload(5), 8'h00, 0, 2, 2);
    wait_idle(500);

    // Repeated HDR0 before HDR1, single-byte frame.
    p = '{8'h7F};
    send_frame(p, 8'h00, 1, 1, 1);
    wait_idle(500);

    // Maximum length fills the buffer exactly.
    send_frame(rand_payload(MAXL), 8'h00, 0, 1, 1);
    wait_idle(1000);
    chk("len_max", o_len, MAXL);

    // Stall inside a frame until the idle limit fires.
    err_q.push_back(3);
    send_byte(8'h55, 1, 1);
    send_byte(8'hAA, 1, 1);
    send_byte(8'h02, 1, 1);
    send_byte(8'h01, 1, 1);
    chk("busy_in_frame", o_busy, 1);
    wait_idle(TMO + 100);
    chk("code_tmo", o_err_code, 3);
    chk("busy_after_tmo", o_busy, 0);
    send_frame(rand_payload(2), 8'h00, 0, 1, 1);
    wait_idle(500);

    // Back-pressure with one byte arriving mid-drain; 5-cycle valid levels.
    ready_mode = 3;
    send_frame(rand_payload(4), 8'h00, 0, 5, 1);
    n = 0;
    while (!o_valid && n < 100) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    chk("drain_started", o_valid, 1);
    ovr_exp++;
    send_byte(8'h55, 5, 1);
    ready_mode = 1;
    wait_idle(500);
    chk("overrun_count", ovr_seen, ovr_exp);

    // Reset mid-frame: partial frame vanishes silently.
    ready_mode = 0;
    send_byte(8'h55, 1, 1);
    send_byte(8'hAA, 1, 1);
    send_byte(8'h03, 1, 1);
    send_byte(8'h11, 1, 1);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    chk("rst_mid_busy", o_busy, 0);
    chk("rst_mid_err", o_err, 0);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    send_frame(rand_payload(3), 8'h00, 0, 1, 1);
    wait_idle(500);

    // Randomized mix of frame kinds, timings and ready patterns.
    for (int k = 0; k < 40; k++) begin
      int kind, hold, gap;
      kind = $urandom_range(0, 3);
      hold = $urandom_range(1, 3);
      gap  = $urandom_range(1, 3);
      ready_mode = $urandom_range(0, 2);
      case (kind)
        0: send_frame(rand_payload($urandom_range(1, MAXL)), 8'h00, 0, hold, gap);
        1: send_frame(rand_payload($urandom_range(1, MAXL)),
                      8'($urandom_range(1, 255)), 0, hold, gap);
        2: send_bad_len(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255)),
                        hold, gap);
        default: begin
          n = $urandom_range(1, 4);
          for (int j = 0; j < n; j++) begin
            g = 8'($urandom_range(0, 255));
            if (g == 8'h55) g = 8'h00;
            send_byte(g, hold, gap);
          end
          send_frame(rand_payload($urandom_range(1, MAXL)), 8'h00,
                     $urandom_range(0, 2), hold, gap);
        end
      endcase
      wait_idle(2000);
    end

    chk("final_data_q", data_q.size(), 0);
    chk("final_err_q", err_q.size(), 0);
    chk("final_overrun", ovr_seen, ovr_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
